// File: rtl/sram_array.sv
// Single-port synchronous SRAM that clears itself, one word per cycle, after reset before it accepts requests.
// Optional feature: define SRAM_ARRAY_PARITY_EN to store an even-parity bit per word and add the err_inj/perr ports.
module sram_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef SRAM_ARRAY_PARITY_EN
  input  logic              err_inj,
  output logic              perr,
`endif
  output logic              rdy,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef SRAM_ARRAY_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   init_cnt_reg, init_cnt_next;
  logic                rvalid_reg, rvalid_next;
  logic                rd_loaded_reg, rd_loaded_next;
  logic [WORD_W-1:0]   rd_word_reg;

  logic                mem_we;
  logic                mem_re;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [WORD_W-1:0]   mem_wword;
  logic [WORD_W-1:0]   wr_word;

  logic [WORD_W-1:0]   mem [DEPTH];

  // Even parity: the stored word (data plus parity bit) XORs to zero when intact.
`ifdef SRAM_ARRAY_PARITY_EN
  assign wr_word = {(^wdata) ^ err_inj, wdata};
`else
  assign wr_word = wdata;
`endif

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    mem_waddr     = addr;
    mem_wword     = wr_word;
    case (state_reg)
      INIT: begin
        mem_we        = 1'b1;
        mem_waddr     = init_cnt_reg;
        mem_wword     = '0;
        init_cnt_next = init_cnt_reg + 1'b1;
        // DEPTH is a power of two, so the last word is the all-ones address.
        if (&init_cnt_reg) begin
          state_next = READY;
        end
      end
      READY: begin
        if (req) begin
          if (rw) begin
            mem_we = 1'b1;
          end else begin
            mem_re = 1'b1;
          end
        end
      end
      default: begin
        state_next = INIT;
      end
    endcase
  end

  assign rvalid_next    = mem_re;
  assign rd_loaded_next = rd_loaded_reg | mem_re;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= INIT;
      init_cnt_reg  <= '0;
      rvalid_reg    <= 1'b0;
      rd_loaded_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      init_cnt_reg  <= init_cnt_next;
      rvalid_reg    <= rvalid_next;
      rd_loaded_reg <= rd_loaded_next;
    end
  end

  // Storage and its read register carry no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wword;
    end
    if (mem_re) begin
      rd_word_reg <= mem[addr];
    end
  end

  assign rdy    = (state_reg == READY);
  assign rvalid = rvalid_reg;
  // Until the first read after reset the unreset RAM register is masked to zero.
  assign rdata  = rd_loaded_reg ? rd_word_reg[DATA_W-1:0] : '0;

`ifdef SRAM_ARRAY_PARITY_EN
  assign perr = rvalid_reg & (^rd_word_reg);
`endif

endmodule

// File: tb/tb_sram_array.sv
// Directed self-checking bench for sram_array; covers the parity option when SRAM_ARRAY_PARITY_EN is defined.
module tb_sram_array;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic       rw;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic       rdy;
  logic [7:0] rdata;
  logic       rvalid;
`ifdef SRAM_ARRAY_PARITY_EN
  logic       err_inj;
  logic       perr;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_mem [8];

  sram_array #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .rw     (rw),
    .addr   (addr),
    .wdata  (wdata),
`ifdef SRAM_ARRAY_PARITY_EN
    .err_inj(err_inj),
    .perr   (perr),
`endif
    .rdy    (rdy),
    .rdata  (rdata),
    .rvalid (rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    req = 1'b1; rw = 1'b1; addr = a; wdata = d;
    tick();
    req = 1'b0;
    exp_mem[a] = d;
    chk($sformatf("wr_no_rvalid a%0d", a), {31'd0, rvalid}, 32'd0);
    $display("write addr=%0d data=%02h", a, d);
  endtask

  task automatic do_read(input logic [2:0] a);
    req = 1'b1; rw = 1'b0; addr = a;
    tick();
    req = 1'b0;
    chk($sformatf("rd_rvalid a%0d", a), {31'd0, rvalid}, 32'd1);
    chk($sformatf("rd_data a%0d", a), {24'd0, rdata}, {24'd0, exp_mem[a]});
    tick();
    chk($sformatf("rd_rvalid_drop a%0d", a), {31'd0, rvalid}, 32'd0);
    chk($sformatf("rd_hold a%0d", a), {24'd0, rdata}, {24'd0, exp_mem[a]});
    $display("read  addr=%0d data=%02h", a, rdata);
  endtask

  // Releases reset just after an edge and checks rdy stays low for exactly 8 cycles.
  task automatic release_and_sweep(input string tag, input logic hammer);
    rst_n = 1'b1;
    if (hammer) begin
      req = 1'b1; rw = 1'b1; addr = 3'd4; wdata = 8'hFF;
    end
    chk($sformatf("%s rdy c0", tag), {31'd0, rdy}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("%s rdy c%0d", tag, i), {31'd0, rdy}, 32'd0);
    end
    tick();
    req = 1'b0;
    chk($sformatf("%s rdy up", tag), {31'd0, rdy}, 32'd1);
    for (int i = 0; i < 8; i++) exp_mem[i] = 8'h00;
    $display("%s sweep done", tag);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
`ifdef SRAM_ARRAY_PARITY_EN
    err_inj = 1'b0;
`endif
    repeat (3) tick();
    chk("rst rdy", {31'd0, rdy}, 32'd0);
    chk("rst rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst rdata", {24'd0, rdata}, 32'd0);

    // A write to addr 4 is held on req through the whole clear sweep and must be dropped.
    release_and_sweep("init1", 1'b1);
    chk("idle rvalid", {31'd0, rvalid}, 32'd0);
    for (int i = 0; i < 8; i++) do_read(3'(i));

    do_write(3'd0, 8'h03);
    do_write(3'd1, 8'h05);
    req = 1'b1; rw = 1'b0; addr = 3'd0;
    tick();
    chk("b2b rvalid0", {31'd0, rvalid}, 32'd1);
    chk("b2b data0", {24'd0, rdata}, 32'h03);
    addr = 3'd1;
    tick();
    req = 1'b0;
    chk("b2b rvalid1", {31'd0, rvalid}, 32'd1);
    chk("b2b data1", {24'd0, rdata}, 32'h05);
    tick();
    chk("b2b rvalid_drop", {31'd0, rvalid}, 32'd0);
    chk("b2b hold", {24'd0, rdata}, 32'h05);
    $display("back-to-back reads done");

    // Read immediately following a write to the same address.
    req = 1'b1; rw = 1'b1; addr = 3'd2; wdata = 8'hA5;
    tick();
    exp_mem[2] = 8'hA5;
    rw = 1'b0;
    tick();
    req = 1'b0;
    chk("raw rvalid", {31'd0, rvalid}, 32'd1);
    chk("raw data", {24'd0, rdata}, 32'hA5);
    $display("write-then-read addr=2 data=%02h", rdata);
    for (int i = 0; i < 8; i++) do_read(3'(i));

    // Reset asserted mid-cycle while a read is pending.
    req = 1'b1; rw = 1'b0; addr = 3'd2;
    #2;
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    chk("midrst rvalid", {31'd0, rvalid}, 32'd0);
    chk("midrst rdy", {31'd0, rdy}, 32'd0);
    chk("midrst rdata", {24'd0, rdata}, 32'd0);
    tick();
    chk("midrst rvalid edge", {31'd0, rvalid}, 32'd0);
    tick();
    release_and_sweep("init2", 1'b0);
    for (int i = 0; i < 8; i++) do_read(3'(i));

`ifdef SRAM_ARRAY_PARITY_EN
    req = 1'b1; rw = 1'b1; addr = 3'd6; wdata = 8'h0F; err_inj = 1'b1;
    tick();
    err_inj = 1'b0;
    exp_mem[6] = 8'h0F;
    rw = 1'b0;
    tick();
    req = 1'b0;
    chk("par rvalid", {31'd0, rvalid}, 32'd1);
    chk("par data", {24'd0, rdata}, 32'h0F);
    chk("par perr", {31'd0, perr}, 32'd1);
    tick();
    chk("par perr idle", {31'd0, perr}, 32'd0);
    do_write(3'd5, 8'h3C);
    req = 1'b1; rw = 1'b0; addr = 3'd5;
    tick();
    req = 1'b0;
    chk("par ok data", {24'd0, rdata}, 32'h3C);
    chk("par ok perr", {31'd0, perr}, 32'd0);
    $display("parity checks done");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_array.md
SRAM_ARRAY -- requirements
Module: sram_array

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 3, meaning address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port req  input  1  access request, sampled on clk rising edge.
REQ-006 The block SHALL have port rw  input  1  access type: 1 = write, 0 = read.
REQ-007 The block SHALL have port addr  input  ADDR_W  word address.
REQ-008 The block SHALL have port wdata  input  DATA_W  write data.
REQ-009 The block SHALL have port rdy  output  1  block accepts requests this cycle.
REQ-010 The block SHALL have port rdata  output  DATA_W  read data.
REQ-011 The block SHALL have port rvalid  output  1  one-cycle pulse: rdata carries a new read result.

Function
REQ-012 The block SHALL implement a two-state FSM with states INIT and READY.
REQ-013 In INIT the block SHALL write zero to word init_cnt each cycle, init_cnt counting 0 to DEPTH-1, hold rdy=0, and ignore req.
REQ-014 The block SHALL move from INIT to READY on the cycle after word DEPTH-1 is cleared, so rdy first rises exactly DEPTH cycles after rst_n deasserts.
REQ-015 READY SHALL have no exit except reset; rdy SHALL be 1 in READY.
REQ-016 A request SHALL be accepted when req=1 and rdy=1 on a rising clk edge; a request with rdy=0 SHALL be dropped with no side effect.
REQ-017 An accepted write SHALL update mem[addr] with wdata at that edge; write latency is one cycle and produces no rvalid.
REQ-018 An accepted read SHALL drive rdata=mem[addr] and rvalid=1 in the following cycle (latency 1).
REQ-019 rvalid SHALL be 0 in every cycle not following an accepted read.
REQ-020 rdata SHALL hold its last read value until the next read completes.
REQ-021 Back-to-back requests SHALL be accepted every cycle; a read in the cycle after a write to the same address SHALL return the new data.
REQ-022 Words not addressed by an accepted write SHALL retain their contents.

Reset
REQ-023 Asserting rst_n=0 SHALL immediately force state=INIT, init_cnt=0, rdy=0, rvalid=0, rdata=0.
REQ-024 Reset in mid-operation SHALL abort any pending read, so no rvalid is produced, and restart the full clear sweep.
REQ-025 After reset deasserts, every word SHALL read 0.

Configuration
REQ-026 With macro SRAM_ARRAY_PARITY_EN defined, each word SHALL store one extra even-parity bit, computed from wdata on write and set to 0 during INIT.
REQ-027 With SRAM_ARRAY_PARITY_EN defined, the block SHALL add port perr  output  1, asserted together with rvalid when the stored parity does not match the read data.
REQ-028 With SRAM_ARRAY_PARITY_EN defined, the block SHALL add port err_inj  input  1; when err_inj=1 on an accepted write, the stored parity bit SHALL be inverted.
REQ-029 With SRAM_ARRAY_PARITY_EN defined, perr SHALL reset to 0 and SHALL be 0 whenever rvalid=0.
REQ-030 Without SRAM_ARRAY_PARITY_EN, the perr and err_inj ports and the parity storage SHALL be absent, with behaviour otherwise identical.

Verification
REQ-031 Reset then idle (defaults): rdy=0 for exactly 8 cycles after rst_n rises, then 1; reads of addresses 0..7 return 0.
REQ-032 Write 0x03 to addr 0, then write 0x05 to addr 1, then read addr 0 and addr 1 back-to-back: rdata=0x03 and then 0x05, each with a one-cycle rvalid, one cycle after each read request.
REQ-033 Write 0xA5 to addr 2 and read addr 2 in the next cycle: rdata=0xA5; reads of addrs 0, 1, 3..7 are unchanged.
REQ-034 req=1 write of 0xFF to addr 4 during INIT: after INIT, a read of addr 4 returns 0x00.
REQ-035 Issue a read, then assert rst_n=0 before the next edge: no rvalid appears, and rdy stays 0 for 8 cycles after release.
REQ-036 With SRAM_ARRAY_PARITY_EN defined, write 0x0F with err_inj=1 to addr 6, then read addr 6: rdata=0x0F, rvalid=1, perr=1; a normal write followed by a read gives perr=0.
